// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with debounce and ghost rejection.
// Columns are driven low one at a time. Rows are synchronized and sampled on
// the last cycle of each column's dwell. A full scan is judged on the col_4
// sample cycle and a debounce FSM turns stable single-key scans into
// one-cycle press pulses.
module keypad_scanner #(
   parameter int unsigned SCAN_DIV       = 100000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       row_1,
   input  logic       row_2,
   input  logic       row_3,
   input  logic       row_4,
   output logic       col_1,
   output logic       col_2,
   output logic       col_3,
   output logic       col_4,
   output logic       keydown_num,
   output logic       keydown_start,
   output logic       keydown_confirm,
   output logic       keydown_clear,
   output logic [3:0] num
);

   localparam int unsigned   DivW      = $clog2(SCAN_DIV);
   localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
   localparam logic [3:0]    DebTarget = 4'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      StIdle,
      StPressChk,
      StHeld,
      StRelChk
   } state_e;

   // Row synchronizers (rows are active-low, so reset to idle-high)
   logic [3:0] row_raw;
   logic [3:0] row_meta_q;
   logic [3:0] row_sync_q;

   // Column scan
   logic [DivW-1:0] div_q, div_d;
   logic [1:0]      col_idx_q, col_idx_d;
   logic [3:0]      col_q, col_d;
   logic            sample;
   logic            eval;

   // Pressed-key image, indexed [row][col], 1 = pressed
   logic [3:0][3:0] keys_q, keys_d;

   // Scan classification
   logic [4:0] hit_cnt;
   logic [3:0] hit_code;
   logic       hit_none;
   logic       hit_single;

   // Key decode of hit_code
   logic       dec_digit_vld;
   logic [3:0] dec_digit;
   logic       dec_start;
   logic       dec_confirm;
   logic       dec_clear;

   // Debounce FSM
   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] cand_q, cand_d;
   logic       accept;

   // Outputs, pulse bits ordered {clear, confirm, start, num}
   logic [3:0] kd_q, kd_d;
   logic [3:0] num_q, num_d;

   assign row_raw = {row_4, row_3, row_2, row_1};

   // Two-flop synchronizer on every row
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_meta_q <= 4'hF;
         row_sync_q <= 4'hF;
      end else begin
         row_meta_q <= row_raw;
         row_sync_q <= row_meta_q;
      end
   end

   // Dwell counter and column index advance; column drive follows the index
   always_comb begin
      sample    = (div_q == DivLast);
      eval      = sample && (col_idx_q == 2'd3);
      div_d     = sample ? '0 : div_q + DivW'(1);
      col_idx_d = sample ? col_idx_q + 2'd1 : col_idx_q;
      col_d     = ~(4'b0001 << col_idx_d);
   end

   // Column scan state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q     <= '0;
         col_idx_q <= 2'd0;
         col_q     <= 4'b1110;
      end else begin
         div_q     <= div_d;
         col_idx_q <= col_idx_d;
         col_q     <= col_d;
      end
   end

   // Capture the driven column's rows into the key image on the sample cycle
   always_comb begin
      keys_d = keys_q;
      if (sample) begin
         for (int r = 0; r < 4; r++) begin
            keys_d[r][col_idx_q] = ~row_sync_q[r];
         end
      end
   end

   // Key image register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         keys_q <= '0;
      end else begin
         keys_q <= keys_d;
      end
   end

   // Count pressed keys; col_4 is taken live from keys_d on the eval cycle
   always_comb begin
      hit_cnt  = '0;
      hit_code = '0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys_d[r][c]) begin
               hit_cnt  = hit_cnt + 5'd1;
               hit_code = {2'(r), 2'(c)};
            end
         end
      end
      hit_none   = (hit_cnt == 5'd0);
      hit_single = (hit_cnt == 5'd1);
   end

   // Map {row,col} code to key function; *, # and D fall to default
   always_comb begin
      dec_digit_vld = 1'b0;
      dec_digit     = 4'd0;
      dec_start     = 1'b0;
      dec_confirm   = 1'b0;
      dec_clear     = 1'b0;
      case (hit_code)
         4'h0: begin dec_digit_vld = 1'b1; dec_digit = 4'd1; end
         4'h1: begin dec_digit_vld = 1'b1; dec_digit = 4'd2; end
         4'h2: begin dec_digit_vld = 1'b1; dec_digit = 4'd3; end
         4'h3: dec_start = 1'b1;
         4'h4: begin dec_digit_vld = 1'b1; dec_digit = 4'd4; end
         4'h5: begin dec_digit_vld = 1'b1; dec_digit = 4'd5; end
         4'h6: begin dec_digit_vld = 1'b1; dec_digit = 4'd6; end
         4'h7: dec_confirm = 1'b1;
         4'h8: begin dec_digit_vld = 1'b1; dec_digit = 4'd7; end
         4'h9: begin dec_digit_vld = 1'b1; dec_digit = 4'd8; end
         4'hA: begin dec_digit_vld = 1'b1; dec_digit = 4'd9; end
         4'hB: dec_clear = 1'b1;
         4'hD: begin dec_digit_vld = 1'b1; dec_digit = 4'd0; end
         default: ;
      endcase
   end

   // Debounce FSM next state; only moves on a scan evaluation.
   // MULTI is never a press and counts as "key present" during release.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      accept  = 1'b0;
      if (eval) begin
         unique case (state_q)
            StIdle: begin
               if (hit_single) begin
                  cand_d = hit_code;
                  cnt_d  = 4'd1;
                  if (DebTarget == 4'd1) begin
                     state_d = StHeld;
                     accept  = 1'b1;
                  end else begin
                     state_d = StPressChk;
                  end
               end
            end
            StPressChk: begin
               if (hit_single) begin
                  if (hit_code == cand_q) begin
                     cnt_d = cnt_q + 4'd1;
                     if (cnt_q + 4'd1 == DebTarget) begin
                        state_d = StHeld;
                        accept  = 1'b1;
                     end
                  end else begin
                     cand_d = hit_code;
                     cnt_d  = 4'd1;
                  end
               end else begin
                  state_d = StIdle;
                  cnt_d   = 4'd0;
               end
            end
            StHeld: begin
               if (hit_none) begin
                  if (DebTarget == 4'd1) begin
                     state_d = StIdle;
                     cnt_d   = 4'd0;
                  end else begin
                     state_d = StRelChk;
                     cnt_d   = 4'd1;
                  end
               end
            end
            StRelChk: begin
               if (hit_none) begin
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_q + 4'd1 == DebTarget) begin
                     state_d = StIdle;
                     cnt_d   = 4'd0;
                  end
               end else begin
                  state_d = StHeld;
               end
            end
            default: begin
               state_d = StIdle;
               cnt_d   = 4'd0;
            end
         endcase
      end
   end

   // Debounce FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         cand_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cand_q  <= cand_d;
      end
   end

   // Press pulses and digit latch; on accept hit_code equals the candidate
   always_comb begin
      kd_d  = 4'b0000;
      num_d = num_q;
      if (accept) begin
         kd_d = {dec_clear, dec_confirm, dec_start, dec_digit_vld};
         if (dec_digit_vld) begin
            num_d = dec_digit;
         end
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kd_q  <= 4'b0000;
         num_q <= 4'd0;
      end else begin
         kd_q  <= kd_d;
         num_q <= num_d;
      end
   end

   assign col_1           = col_q[0];
   assign col_2           = col_q[1];
   assign col_3           = col_q[2];
   assign col_4           = col_q[3];
   assign keydown_num     = kd_q[0];
   assign keydown_start   = kd_q[1];
   assign keydown_confirm = kd_q[2];
   assign keydown_clear   = kd_q[3];
   assign num             = num_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives the rows from the
// column outputs; expected pulses (kind, num, cycle) are queued when keys are
// driven and popped when the DUT pulses.
module tb_keypad_scanner;

   localparam int unsigned ScanDiv = 4;
   localparam int unsigned Deb     = 3;
   localparam int          ScanCyc = 16;

   localparam logic [3:0] KNone = 4'b0000;
   localparam logic [3:0] KNum  = 4'b0001;
   localparam logic [3:0] KSt   = 4'b0010;
   localparam logic [3:0] KCf   = 4'b0100;
   localparam logic [3:0] KCl   = 4'b1000;

   typedef struct {
      logic [15:0] mask;
      int          scans;
      logic [3:0]  kind;
      logic [3:0]  num;
      int          at;
   } step_t;

   typedef struct {
      logic [3:0] kind;
      logic [3:0] num;
      int         cyc;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       row_1, row_2, row_3, row_4;
   logic       col_1, col_2, col_3, col_4;
   logic       keydown_num, keydown_start, keydown_confirm, keydown_clear;
   logic [3:0] num;

   logic [15:0] mask;   // pressed keys, bit r*4+c
   logic [3:0]  rows;
   logic [3:0]  cols;
   logic [3:0]  obs;
   int          cyc;
   int          checks;
   int          errors;
   exp_t        exp_q[$];
   step_t       tbl[$];

   keypad_scanner #(
      .SCAN_DIV      (ScanDiv),
      .DEBOUNCE_SCANS(Deb)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .row_1          (row_1),
      .row_2          (row_2),
      .row_3          (row_3),
      .row_4          (row_4),
      .col_1          (col_1),
      .col_2          (col_2),
      .col_3          (col_3),
      .col_4          (col_4),
      .keydown_num    (keydown_num),
      .keydown_start  (keydown_start),
      .keydown_confirm(keydown_confirm),
      .keydown_clear  (keydown_clear),
      .num            (num)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign cols = {col_4, col_3, col_2, col_1};
   assign obs  = {keydown_clear, keydown_confirm, keydown_start, keydown_num};

   // Keypad matrix: a pressed key pulls its row low while its column is low
   always_comb begin
      rows = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (mask[r*4+c] && !cols[c]) rows[r] = 1'b0;
         end
      end
   end
   assign row_1 = rows[0];
   assign row_2 = rows[1];
   assign row_3 = rows[2];
   assign row_4 = rows[3];

   // Cycles since reset release
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Monitor: one-hot-low columns every cycle, pulses against the scoreboard
   always @(negedge clk) begin
      checks++;
      if (!$onehot(~cols)) begin
         errors++;
         $display("FAIL col_onehot: cols=%b required exactly one low", cols);
      end
      if (rst_n) begin
         if (obs != 4'b0000) begin
            checks++;
            if (!$onehot(obs)) begin
               errors++;
               $display("FAIL pulse_onehot: keydown=%b at cyc %0d", obs, cyc);
            end else if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pulse: keydown=%b num=%0d at cyc %0d", obs, num, cyc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (obs !== e.kind || num !== e.num || cyc != e.cyc) begin
                  errors++;
                  $display("FAIL pulse: keydown=%b num=%0d cyc=%0d required %b num=%0d cyc=%0d",
                           obs, num, cyc, e.kind, e.num, e.cyc);
               end
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_pulse: no pulse at cyc %0d required %b num=%0d",
                     e.cyc, e.kind, e.num);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic check_reset_state(input string name);
      check({name, "_cols"}, 32'(cols), 32'hE);
      check({name, "_pulses"}, 32'(obs), 32'h0);
      check({name, "_num"}, 32'(num), 32'h0);
   endtask

   // Wait for the negedge just after a scan evaluation
   task automatic align();
      do @(negedge clk); while (cyc % ScanCyc != 0);
   endtask

   task automatic run_step(input step_t s);
      int base;
      base = cyc;
      mask = s.mask;
      if (s.kind != KNone) begin
         exp_q.push_back('{kind: s.kind, num: s.num, cyc: base + ScanCyc * s.at});
      end
      repeat (ScanCyc * s.scans) @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      mask   = 16'h0;
      rst_n  = 1'b0;

      // key masks: 1=0001 2=0002 3=0004 A=0008 4=0010 5=0020 6=0040 B=0080
      //            7=0100 8=0200 9=0400 C=0800 *=1000 0=2000 #=4000 D=8000
      tbl.push_back('{16'h0100, 5, KNum, 4'd7, 3});  // hold 7
      tbl.push_back('{16'h0000, 3, KNone, 4'd0, 0});
      tbl.push_back('{16'h0008, 2, KNone, 4'd0, 0}); // A too short
      tbl.push_back('{16'h0000, 1, KNone, 4'd0, 0});
      tbl.push_back('{16'h0008, 3, KSt, 4'd7, 3});
      tbl.push_back('{16'h0000, 3, KNone, 4'd0, 0});
      tbl.push_back('{16'h0021, 5, KNone, 4'd0, 0}); // 1+5 ghost
      tbl.push_back('{16'h0001, 4, KNum, 4'd1, 3});
      tbl.push_back('{16'h0000, 3, KNone, 4'd0, 0});
      tbl.push_back('{16'h0800, 3, KCl, 4'd1, 3});   // C bounce
      tbl.push_back('{16'h0000, 1, KNone, 4'd0, 0});
      tbl.push_back('{16'h0800, 3, KNone, 4'd0, 0});
      tbl.push_back('{16'h0000, 3, KNone, 4'd0, 0});
      tbl.push_back('{16'h0800, 3, KCl, 4'd1, 3});
      tbl.push_back('{16'h0000, 3, KNone, 4'd0, 0});
      tbl.push_back('{16'h0080, 3, KCf, 4'd1, 3});
      tbl.push_back('{16'h0000, 3, KNone, 4'd0, 0});
      tbl.push_back('{16'h2000, 3, KNum, 4'd0, 3});
      tbl.push_back('{16'h0000, 3, KNone, 4'd0, 0});
      tbl.push_back('{16'h1000, 3, KNone, 4'd0, 0}); // * silent
      tbl.push_back('{16'h0000, 3, KNone, 4'd0, 0});
      tbl.push_back('{16'h4000, 3, KNone, 4'd0, 0}); // # silent
      tbl.push_back('{16'h0000, 3, KNone, 4'd0, 0});
      tbl.push_back('{16'h8000, 4, KNone, 4'd0, 0}); // D silent
      tbl.push_back('{16'h0000, 3, KNone, 4'd0, 0});
      tbl.push_back('{16'h0002, 2, KNone, 4'd0, 0}); // 2 then switch to 3
      tbl.push_back('{16'h0004, 3, KNum, 4'd3, 3});
      tbl.push_back('{16'h0000, 3, KNone, 4'd0, 0});
      tbl.push_back('{16'h0010, 3, KNum, 4'd4, 3});
      tbl.push_back('{16'h0050, 2, KNone, 4'd0, 0}); // MULTI while held
      tbl.push_back('{16'h0000, 3, KNone, 4'd0, 0});
      tbl.push_back('{16'h0200, 3, KNum, 4'd8, 3});
      tbl.push_back('{16'h0000, 2, KNone, 4'd0, 0}); // partial release
      tbl.push_back('{16'h0200, 2, KNone, 4'd0, 0});
      tbl.push_back('{16'h0000, 3, KNone, 4'd0, 0});

      repeat (3) @(negedge clk);
      check_reset_state("reset");
      rst_n = 1'b1;
      align();

      foreach (tbl[i]) run_step(tbl[i]);
      check("queue_after_table", 32'(exp_q.size()), 32'd0);
      check("num_after_table", 32'(num), 32'd8);

      // Reset asserted while a pulse is high
      begin
         step_t s;
         s = '{16'h0020, 3, KNum, 4'd5, 3};
         run_step(s);
         #1;
         check("pulse_before_reset", 32'(keydown_num), 32'd1);
         check("num_before_reset", 32'(num), 32'd5);
         rst_n = 1'b0;
         #1;
         check_reset_state("reset_mid_pulse");
      end
      repeat (3) @(negedge clk);
      mask  = 16'h0;
      rst_n = 1'b1;
      align();

      // Reset during PRESS_CHK of 9 with cnt=2, 9 kept held through reset
      mask = 16'h0400;
      repeat (2 * ScanCyc + 8) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_state("reset_mid_debounce");
      repeat (4) @(negedge clk);
      check_reset_state("reset_held");
      rst_n = 1'b1;
      exp_q.push_back('{kind: KNum, num: 4'd9, cyc: ScanCyc * Deb});
      repeat (ScanCyc * Deb + 12) @(negedge clk);
      check("queue_after_reset_press", 32'(exp_q.size()), 32'd0);
      check("num_after_reset_press", 32'(num), 32'd9);
      mask = 16'h0;
      align();
      repeat (ScanCyc * Deb) @(negedge clk);

      // One-cycle row glitch right after col_1 goes low, well before sampling
      for (int k = 0; k < 4; k++) begin
         mask = 16'h0100;
         @(negedge clk);
         mask = 16'h0000;
         repeat (ScanCyc - 1) @(negedge clk);
      end
      repeat (2 * ScanCyc) @(negedge clk);
      check("queue_final", 32'(exp_q.size()), 32'd0);
      check("num_final", 32'(num), 32'd9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000: clk cycles each column is driven; legal range is 4 or more.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4: consecutive identical full scans needed to accept a press or a release; legal range is 1 to 15.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have ports row_1..row_4, input, 1 bit each: matrix rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 SHALL have ports col_1..col_4, output, 1 bit each: matrix column drives, active-low, registered.
REQ-007 SHALL have ports keydown_num, keydown_start, keydown_confirm, keydown_clear, output, 1 bit each: one-cycle press pulses.
REQ-008 SHALL have port num, output, 4 bits: last accepted digit, 0-9.

Function
REQ-009 SHALL map keys (row,col) as: r1 = 1 2 3 A; r2 = 4 5 6 B; r3 = 7 8 9 C; r4 = * 0 # D.
REQ-010 SHALL treat A as start, B as confirm and C as clear; *, # and D are valid keys that produce no pulse.
REQ-011 SHALL drive exactly one col low at all times, in the order col_1 → col_4 → col_1, holding each column for SCAN_DIV cycles.
REQ-012 SHALL pass each row through a 2-flop synchronizer before use.
REQ-013 SHALL sample the synchronized rows on the last cycle of each column's dwell.
REQ-014 SHALL evaluate a scan result on the col_4 sample cycle, as one of: NONE (0 keys), SINGLE(code) (exactly 1 key), or MULTI (2 or more keys).
REQ-015 SHALL treat MULTI identically to NONE for press acceptance (ghost rejection).
REQ-016 SHALL implement an FSM with states IDLE, PRESS_CHK, HELD and REL_CHK, updated once per scan evaluation; a counter cnt counts matching scans.
REQ-017 In IDLE, SINGLE(k) SHALL set cand=k and cnt=1 and go to PRESS_CHK; any other result stays in IDLE.
REQ-018 In PRESS_CHK, SINGLE(cand) SHALL increment cnt; SINGLE(other) SHALL set cand=other and cnt=1; NONE or MULTI SHALL go to IDLE.
REQ-019 When cnt reaches DEBOUNCE_SCANS, the FSM SHALL go to HELD and emit the pulse for cand; with DEBOUNCE_SCANS=1, the first SINGLE goes directly from IDLE to HELD with the pulse.
REQ-020 The press pulse SHALL be high for exactly one clk cycle, the cycle after the accepting evaluation.
REQ-021 In HELD, NONE SHALL set cnt=1 and go to REL_CHK; SINGLE and MULTI SHALL stay in HELD with no pulse.
REQ-022 In REL_CHK, NONE SHALL increment cnt and go to IDLE when cnt reaches DEBOUNCE_SCANS; any key SHALL return to HELD.
REQ-023 A second press SHALL produce a pulse only after release is accepted and a full press debounce completes.
REQ-024 num SHALL update to the digit value in the same cycle keydown_num pulses.
REQ-025 num SHALL hold its value otherwise, including across start, confirm and clear pulses.
REQ-026 At most one keydown_* output SHALL be high in any cycle.
REQ-027 The column dwell counter SHALL wrap from SCAN_DIV-1 to 0.
REQ-028 The column index SHALL wrap from 3 to 0.
REQ-029 Row changes between sample cycles SHALL have no effect.

Reset
REQ-030 While rst_n=0, the block SHALL be in this state: col_1=0 and col_2..col_4=1, column index 0, dwell counter 0, FSM=IDLE, cnt=0, cand=0, all keydown_*=0, num=0, synchronizers=1.
REQ-031 Reset asserted mid-debounce or mid-pulse SHALL clear the pulse immediately and discard the partial press.
REQ-032 After rst_n deasserts, scanning SHALL restart at col_1 on the next clk edge.
REQ-033 A key already held when reset deasserts SHALL be reported once, after DEBOUNCE_SCANS scans.

Verification
REQ-034 The bench SHALL use SCAN_DIV=4 and DEBOUNCE_SCANS=3 (one scan = 16 cycles) for every scenario below.
REQ-035 Scenario: hold key "7" (r3,c1) stable → exactly one keydown_num pulse, num=7, on the cycle after the 3rd col_4 evaluation; no further pulse while held.
REQ-036 Scenario: press "A" for 2 scans then release → no pulse; press "A" for 3 scans → one keydown_start pulse; num unchanged.
REQ-037 Scenario: hold "1" and "5" together for 5 scans → no pulse; release "5" → keydown_num with num=1 after 3 further scans.
REQ-038 Scenario: press "C", release for 1 scan, hold again → only one keydown_clear pulse; release for 3 scans, then press "C" → second pulse.
REQ-039 Scenario: drive rst_n=0 during PRESS_CHK of "9" with cnt=2 → all outputs at reset values, col_1=0; after release of reset, "9" still held → pulse after 3 new scans, num=9.
REQ-040 Scenario: toggle a row between sample cycles → no effect; col outputs are one-hot-low in every cycle throughout.
